// File: rtl/imem_loadable.sv
// imem_loadable -- run-time loadable instruction memory.
//
// Purpose: a debug/UART loader streams the program image in as bytes. The
// bytes are assembled big-endian into NBITS-wide words and written to
// consecutive word addresses. Once the image is complete, the IF stage reads
// it through a registered fetch port addressed by the byte PC.
// A load ends in either of two ways:
//   - a word equal to HALT_WORD is written;
//   - the memory is full.
//
// Optional feature: define IMEM_DBG_READ_EN to add a debug readback port
// (i_dbg_addr / o_dbg_word). This port reads the memory every cycle.
//
// Ports:
//   i_clk, i_reset     clock; asynchronous active-high reset
//   i_load_start       pulse: begin/restart a load (beats a same-cycle byte)
//   i_byte, i_byte_valid, o_byte_ready   byte stream handshake
//   i_fetch_en, i_pc   fetch strobe and byte address
//   o_instruction      registered fetched word (0 on fault or when not ready)
//   o_fault            registered: last fetch misaligned or out of range
//   o_loaded           image ready for fetch
//   o_halt_seen        last load ended on HALT_WORD
//   o_word_count       words written by the current/last load
//   i_dbg_addr, o_dbg_word  (IMEM_DBG_READ_EN only) 1-cycle readback
module imem_loadable #(
  parameter int               NBITS     = 32,
  parameter int               DEPTH     = 64,
  parameter logic [NBITS-1:0] HALT_WORD = {NBITS{1'b1}},
  localparam int              AW        = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load_start,
  input  logic [7:0]       i_byte,
  input  logic             i_byte_valid,
  output logic             o_byte_ready,
  input  logic             i_fetch_en,
  input  logic [NBITS-1:0] i_pc,
  output logic [NBITS-1:0] o_instruction,
  output logic             o_fault,
  output logic             o_loaded,
  output logic             o_halt_seen,
`ifdef IMEM_DBG_READ_EN
  input  logic [AW-1:0]    i_dbg_addr,
  output logic [NBITS-1:0] o_dbg_word,
`endif
  output logic [AW:0]      o_word_count
);

  localparam int BPW = NBITS / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  // One past the last valid byte address; one bit wider than i_pc so it
  // cannot wrap.
  localparam logic [NBITS:0] PC_LIM = (NBITS+1)'(DEPTH * 4);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_READY} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [AW:0]      word_cnt_q, word_cnt_d;
  logic             halt_q, halt_d;
  logic [NBITS-1:0] instr_q, instr_d;
  logic             fault_q, fault_d;
  logic [NBITS-1:0] asm_q;
  logic [NBITS-1:0] asm_next;
  logic             byte_acc;
  logic             mem_we;
  logic             pc_bad;
  logic [AW-1:0]    fetch_idx;

  logic [NBITS-1:0] mem [DEPTH];

  assign o_byte_ready = (state_q == ST_LOAD) & ~i_load_start;
  assign byte_acc     = o_byte_ready & i_byte_valid;

  // Shift-in makes the first accepted byte end up in the top byte lane.
  assign asm_next  = (asm_q << 8) | NBITS'(i_byte);

  assign pc_bad    = (|i_pc[1:0]) | ({1'b0, i_pc} >= PC_LIM);
  assign fetch_idx = i_pc[AW+1:2];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    halt_d     = halt_q;
    instr_d    = instr_q;
    fault_d    = fault_q;
    mem_we     = 1'b0;

    if (i_load_start) begin
      // Restart from any state; any partially assembled word is abandoned.
      state_d    = ST_LOAD;
      wr_ptr_d   = '0;
      byte_cnt_d = '0;
      word_cnt_d = '0;
      halt_d     = 1'b0;
    end else if (byte_acc) begin
      if (byte_cnt_q == BCW'(BPW - 1)) begin
        mem_we     = 1'b1;
        wr_ptr_d   = wr_ptr_q + AW'(1);
        word_cnt_d = word_cnt_q + (AW+1)'(1);
        byte_cnt_d = '0;
        // HALT is tested first so a HALT in the last slot still reports it.
        if (asm_next == HALT_WORD) begin
          halt_d  = 1'b1;
          state_d = ST_READY;
        end else if (wr_ptr_q == AW'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end else begin
        byte_cnt_d = byte_cnt_q + BCW'(1);
      end
    end

    if (state_q == ST_READY) begin
      if (i_fetch_en) begin
        if (pc_bad) begin
          instr_d = '0;
          fault_d = 1'b1;
        end else begin
          instr_d = mem[fetch_idx];
          fault_d = 1'b0;
        end
      end
    end else begin
      instr_d = '0;
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      halt_q     <= 1'b0;
      instr_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      halt_q     <= halt_d;
      instr_q    <= instr_d;
      fault_q    <= fault_d;
    end
  end

  // Storage and the assembly shifter are deliberately unreset so that the
  // image survives reset and load restarts.
  always_ff @(posedge i_clk) begin
    if (byte_acc) begin
      asm_q <= asm_next;
    end
    if (mem_we) begin
      mem[wr_ptr_q] <= asm_next;
    end
  end

`ifdef IMEM_DBG_READ_EN
  logic [NBITS-1:0] dbg_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      dbg_q <= '0;
    end else begin
      dbg_q <= mem[i_dbg_addr];
    end
  end

  assign o_dbg_word = dbg_q;
`endif

  assign o_instruction = instr_q;
  assign o_fault       = fault_q;
  assign o_loaded      = (state_q == ST_READY);
  assign o_halt_seen   = halt_q;
  assign o_word_count  = word_cnt_q;

endmodule

// File: tb/tb_imem_loadable.sv
module tb_imem_loadable;
  localparam int NBITS = 32;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_load_start = 1'b0;
  logic [7:0]    i_byte = 8'h00;
  logic          i_byte_valid = 1'b0;
  logic          o_byte_ready;
  logic          i_fetch_en = 1'b0;
  logic [31:0]   i_pc = 32'h0;
  logic [31:0]   o_instruction;
  logic          o_fault;
  logic          o_loaded;
  logic          o_halt_seen;
  logic [AW:0]   o_word_count;
`ifdef IMEM_DBG_READ_EN
  logic [AW-1:0] i_dbg_addr = '0;
  logic [31:0]   o_dbg_word;
`endif

  imem_loadable #(.NBITS(NBITS), .DEPTH(DEPTH), .HALT_WORD(HALT)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_load_start(i_load_start),
    .i_byte(i_byte), .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready),
    .i_fetch_en(i_fetch_en), .i_pc(i_pc), .o_instruction(o_instruction),
    .o_fault(o_fault), .o_loaded(o_loaded), .o_halt_seen(o_halt_seen),
`ifdef IMEM_DBG_READ_EN
    .i_dbg_addr(i_dbg_addr), .o_dbg_word(o_dbg_word),
`endif
    .o_word_count(o_word_count)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: image contents plus a few facts about the load.
  logic [31:0] m_mem [DEPTH];
  bit          m_written [DEPTH];
  bit          m_loading, m_ready, m_halt;
  int          m_cnt;
  byte         m_bytes [$];
  logic [31:0] m_instr;
  bit          m_fault;
  logic [31:0] m_dbg;
  bit          m_dbg_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".instr"},  o_instruction, m_instr);
    chk({where, ".fault"},  32'(o_fault), 32'(m_fault));
    chk({where, ".loaded"}, 32'(o_loaded), 32'(m_ready));
    chk({where, ".halt"},   32'(o_halt_seen), 32'(m_halt));
    chk({where, ".wcount"}, 32'(o_word_count), 32'(m_cnt));
`ifdef IMEM_DBG_READ_EN
    if (m_dbg_known) chk({where, ".dbg"}, o_dbg_word, m_dbg);
`endif
  endtask

  // Applies one clock with the inputs as currently driven, advancing the
  // model from the rules for that cycle, then checks the registered outputs.
  task automatic tick(input string where);
    bit exp_ready;
    logic [31:0] w;
    #1;
    exp_ready = m_loading && !i_load_start;
    chk({where, ".ready"}, 32'(o_byte_ready), 32'(exp_ready));
    // Fetch port sees the pre-edge memory and pre-edge readiness.
    if (m_ready) begin
      if (i_fetch_en) begin
        if (i_pc[1:0] != 2'b00 || i_pc >= 32'(DEPTH * 4)) begin
          m_instr = 32'h0; m_fault = 1'b1;
        end else begin
          m_instr = m_mem[i_pc / 4]; m_fault = 1'b0;
        end
      end
    end else begin
      m_instr = 32'h0; m_fault = 1'b0;
    end
`ifdef IMEM_DBG_READ_EN
    m_dbg_known = m_written[i_dbg_addr];
    if (m_dbg_known) m_dbg = m_mem[i_dbg_addr];
`endif
    if (i_load_start) begin
      m_loading = 1; m_ready = 0; m_halt = 0; m_cnt = 0; m_bytes.delete();
    end else if (exp_ready && i_byte_valid) begin
      m_bytes.push_back(i_byte);
      if (m_bytes.size() == 4) begin
        w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
        m_bytes.delete();
        m_mem[m_cnt] = w;
        m_written[m_cnt] = 1;
        m_cnt++;
        if (w == HALT) begin
          m_halt = 1; m_loading = 0; m_ready = 1;
        end else if (m_cnt == DEPTH) begin
          m_loading = 0; m_ready = 1;
        end
      end
    end
    @(posedge i_clk);
    #1;
    check_outputs(where);
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_byte = b; i_byte_valid = 1'b1;
    tick("byte");
    i_byte_valid = 1'b0;
  endtask

  task automatic load_start(input bit with_byte);
    i_load_start = 1'b1; i_byte_valid = with_byte; i_byte = 8'h5A;
    tick("start");
    i_load_start = 1'b0; i_byte_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc);
    i_fetch_en = 1'b1; i_pc = pc;
    tick("fetch");
    i_fetch_en = 1'b0;
  endtask

  task automatic apply_reset();
    i_reset = 1'b1;
    #1;
    m_loading = 0; m_ready = 0; m_halt = 0; m_cnt = 0; m_bytes.delete();
    m_instr = 32'h0; m_fault = 0; m_dbg = 32'h0; m_dbg_known = 1;
    check_outputs("reset");
    chk("reset.ready", 32'(o_byte_ready), 32'h0);
    @(posedge i_clk); #1;
    check_outputs("reset_clk");
    i_reset = 1'b0;
  endtask

  initial begin
    logic [7:0] prog [12];
    logic [7:0] tail [4];
    prog = '{8'h00, 8'h22, 8'h20, 8'h20, 8'h8C, 8'h62, 8'h00, 8'h02,
             8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tail = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < DEPTH; i++) m_written[i] = 0;

    #2;
    apply_reset();
    fetch(32'h0);                       // idle: NOP, no fault

    // Three-word program terminated by HALT.
    load_start(1'b0);
    foreach (prog[i]) send_byte(prog[i]);
    chk("prog.loaded", 32'(o_loaded), 32'h1);
    chk("prog.wcount", 32'(o_word_count), 32'd3);
    send_byte(8'h11);                   // READY: not accepted
`ifdef IMEM_DBG_READ_EN
    i_dbg_addr = 2'd1;
`endif
    fetch(32'h0);
    chk("prog.w0", o_instruction, 32'h0022_2020);
`ifdef IMEM_DBG_READ_EN
    chk("prog.dbg1", o_dbg_word, 32'h8C62_0002);
`endif
    fetch(32'h4);
    chk("prog.w1", o_instruction, 32'h8C62_0002);
    fetch(32'h8);
    chk("prog.w2", o_instruction, 32'hFFFF_FFFF);
    tick("hold");                       // fetch_en low: output holds

    // Fill the memory with random non-HALT bytes.
    load_start(1'b0);
    for (int i = 0; i < DEPTH * 4; i++) send_byte(8'($urandom_range(0, 254)));
    chk("full.halt", 32'(o_halt_seen), 32'h0);
    chk("full.wcount", 32'(o_word_count), 32'(DEPTH));
    send_byte(8'h42);                   // 17th byte refused
    fetch(32'h2);
    chk("mis.fault", 32'(o_fault), 32'h1);
    fetch(32'(DEPTH * 4));
    chk("oor.fault", 32'(o_fault), 32'h1);
    fetch(32'h4);
    chk("ok.fault", 32'(o_fault), 32'h0);

    // Random fetch / hold mix, including bad addresses.
    for (int i = 0; i < 40; i++) begin
`ifdef IMEM_DBG_READ_EN
      i_dbg_addr = AW'($urandom_range(0, DEPTH - 1));
`endif
      if ($urandom_range(0, 3) == 0) tick("rnd_hold");
      else fetch(32'($urandom_range(0, DEPTH * 4 + 7)));
    end

    // Restart mid-word with a byte offered alongside the start pulse.
    load_start(1'b0);
    send_byte(8'h12);
    send_byte(8'h34);
    load_start(1'b1);
    foreach (tail[i]) send_byte(tail[i]);
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    fetch(32'h0);
    chk("restart.w0", o_instruction, 32'hAABB_CCDD);

    // Asynchronous reset part-way through a load.
    load_start(1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 254)));
    apply_reset();
    fetch(32'h0);
    chk("idle.instr", o_instruction, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised successor to the MIPS instruction memory. The program image is loaded at run time from a byte stream (debug/UART unit) rather than fixed at elaboration. The block assembles bytes into words and writes them sequentially, then serves synchronous registered fetches addressed by the byte PC. It sits between the debug loader and the IF stage, and reports load completion, halt-word detection and fetch faults.

## Interface
- NBITS, 32: instruction width; multiple of 8; BPW = NBITS/8 bytes per word.
- DEPTH, 64: memory depth in words; power of two ≥ 2; AW = $clog2(DEPTH) (local).
- HALT_WORD, {NBITS{1'b1}}: word that terminates a load.
- i_clk  in  1  clock, all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_load_start  in  1  single-cycle pulse; begins or restarts a load.
- i_byte  in  8  load data byte.
- i_byte_valid  in  1  byte present.
- o_byte_ready  out  1  byte accepted when valid & ready.
- i_fetch_en  in  1  fetch strobe (IF-stage stall = 0).
- i_pc  in  NBITS  byte address.
- o_instruction  out  NBITS  registered fetched word.
- o_fault  out  1  registered; fetch was out of range or misaligned.
- o_loaded  out  1  level; image ready for fetch.
- o_halt_seen  out  1  level; last load ended on HALT_WORD.
- o_word_count  out  AW+1  words written in the current/last load.

## Operation
- States: ST_IDLE, ST_LOAD, ST_READY. Reset → ST_IDLE.
- i_load_start in any state → ST_LOAD, with write pointer, byte counter, o_word_count, o_halt_seen and o_loaded all cleared. A partial word is discarded.
- o_byte_ready = (state == ST_LOAD) & ~i_load_start. i_load_start therefore has priority: a byte offered in the same cycle is not accepted.
- Byte assembly is big-endian: first accepted byte → bits [NBITS-1:NBITS-8]. On the BPW-th accepted byte:
  - the assembled word is written to mem[wr_ptr];
  - wr_ptr and o_word_count increment;
  - the byte counter clears.
- Load end, evaluated on the word-write cycle:
  - If the word == HALT_WORD: HALT_WORD is stored, o_halt_seen = 1, → ST_READY.
  - Else if wr_ptr was DEPTH-1 (memory full): → ST_READY, o_halt_seen = 0.
  - If both hold, HALT wins (o_halt_seen = 1).
- o_loaded = (state == ST_READY).
- Fetch is only active in ST_READY with i_fetch_en = 1:
  - i_pc[1:0] ≠ 0, or i_pc ≥ DEPTH·4: o_instruction ← 0 (NOP), o_fault ← 1.
  - Otherwise: o_instruction ← mem[i_pc[AW+1:2]], o_fault ← 0.
- In ST_READY with i_fetch_en = 0: o_instruction and o_fault hold.
- In ST_IDLE or ST_LOAD: o_instruction ← 0 and o_fault ← 0 every cycle.
- Memory contents are not cleared by reset or by i_load_start. Words beyond o_word_count keep stale data.

## Timing
- Reset values: o_instruction = 0, o_fault = 0, o_loaded = 0, o_halt_seen = 0, o_word_count = 0, o_byte_ready = 0; state ST_IDLE.
- Fetch latency is 1 cycle: i_pc sampled at edge N, o_instruction valid after edge N.
- Word write occurs on the edge accepting the last byte. ST_READY and o_loaded take effect on that same edge.
- The first fetch may be issued in the cycle after o_loaded rises, and returns the new data.
- Byte throughput: one byte per cycle; no internal backpressure in ST_LOAD.
- Reset asserted mid-load: immediate return to ST_IDLE with all outputs at reset values. Words already written remain in memory.

## Configuration
- IMEM_DBG_READ_EN defined: adds a debug readback port.
  - Ports: i_dbg_addr (in, AW) and o_dbg_word (out, NBITS).
  - o_dbg_word ← mem[i_dbg_addr] every cycle, in all states, 1-cycle latency; reset value 0.
  - The port is independent of i_fetch_en.
- IMEM_DBG_READ_EN undefined: the ports do not exist and no readback logic is built.

## Test plan
- Reset, then load bytes 00 22 20 20 | 8C 62 00 02 | FF FF FF FF:
  - o_word_count = 3, o_halt_seen = 1, o_loaded rises on the 12th byte edge.
  - Fetch pc = 0, 4, 8 → 0x00222020, 0x8C620002, 0xFFFFFFFF, each 1 cycle later.
- DEPTH = 4, load 16 non-HALT bytes → o_loaded = 1, o_halt_seen = 0, o_word_count = 4. A 17th byte sees o_byte_ready = 0.
- Fetch pc = 2 → 0, o_fault = 1. Fetch pc = DEPTH·4 → 0, o_fault = 1. Next fetch pc = 4 → valid word, o_fault = 0.
- Two bytes sent, then i_load_start pulsed with i_byte_valid = 1:
  - that byte is not accepted and the partial word is dropped;
  - a following 4 bytes AA BB CC DD land at address 0 as 0xAABBCCDD.
- Reset asserted after 6 bytes of a load → all outputs 0, ST_IDLE. A fetch in ST_IDLE returns 0 with o_fault = 0.
- With IMEM_DBG_READ_EN defined: after load, i_dbg_addr = 1 → o_dbg_word = word 1 one cycle later, during a concurrent fetch of pc = 0.
